// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and downstream memory.
interface mem_req_arbiter_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
  );

  // Environment side: requesters plus downstream memory
  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester (inst/data) arbiter onto one memory port with handshake lock
// and an in-order ID FIFO that steers responses back to their requester.
module mem_req_arbiter #(
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  mem_req_arbiter_if.slave   bus,
  output logic               protocol_err
);
  localparam int unsigned   PTR_W    = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OT_DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK_INST, LOCK_DATA} state_t;

  state_t              state;
  logic                last;
  logic                grant;
  logic                full;
  logic                hs;
  logic                pop;
  logic                head;
  logic [OT_DEPTH-1:0] id_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;

  // Locked states pin the grant so a stalled request keeps its fields stable.
  always_comb begin
    grant = 1'b0;
    case (state)
      LOCK_INST: grant = 1'b0;
      LOCK_DATA: grant = 1'b1;
      default: begin
        if (bus.inst_req && bus.data_req) grant = ~last;
        else                              grant = bus.data_req;
      end
    endcase
  end

  assign full = (count == FULL_CNT);
  assign hs   = bus.mem_req & bus.mem_addr_ok;
  assign pop  = bus.mem_data_ok & (count != '0);
  assign head = id_q[rd_ptr];

  always_comb begin
    bus.mem_req   = resetn & ~full & (grant ? bus.data_req : bus.inst_req);
    bus.mem_wr    = grant ? bus.data_wr    : bus.inst_wr;
    bus.mem_size  = grant ? bus.data_size  : bus.inst_size;
    bus.mem_addr  = grant ? bus.data_addr  : bus.inst_addr;
    bus.mem_wstrb = grant ? bus.data_wstrb : bus.inst_wstrb;
    bus.mem_wdata = grant ? bus.data_wdata : bus.inst_wdata;
  end

  assign bus.inst_addr_ok = hs & ~grant;
  assign bus.data_addr_ok = hs & grant;
  assign bus.inst_data_ok = pop & ~head;
  assign bus.data_data_ok = pop & head;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (bus.mem_req && !bus.mem_addr_ok) state <= grant ? LOCK_DATA : LOCK_INST;
        LOCK_INST: if (hs) state <= IDLE;
        LOCK_DATA: if (hs) state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (hs) last <= grant;
    end
  end

  // Push is already blocked when full, so a same-cycle pop never frees a slot early.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (hs) begin
        id_q[wr_ptr] <= grant;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_data_ok && (count == '0)) protocol_err <= 1'b1;
    end
  end
endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter OT_DEPTH, default 4, maximum downstream transactions accepted but not yet answered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, for each requester x in {inst, data}: x_req  input  1  request valid.
REQ-005 SHALL have x_wr  input  1  1=write, 0=read.
REQ-006 SHALL have x_size  input  2  byte-count code (0=1B, 1=2B, 2=4B).
REQ-007 SHALL have x_addr  input  32  byte address.
REQ-008 SHALL have x_wstrb  input  4  byte write strobes.
REQ-009 SHALL have x_wdata  input  32  write data.
REQ-010 SHALL have x_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have x_data_ok  output  1  response for x this cycle.
REQ-012 SHALL have x_rdata  output  32  read data, valid with x_data_ok.
REQ-013 SHALL have downstream ports mem_req (out 1), mem_wr (out 1), mem_size (out 2), mem_addr (out 32), mem_wstrb (out 4), mem_wdata (out 32).
REQ-014 SHALL have downstream ports mem_addr_ok (in 1), mem_data_ok (in 1), mem_rdata (in 32).
REQ-015 SHALL have port protocol_err  output  1  sticky flag: mem_data_ok with no outstanding transaction.

Function
REQ-016 SHALL route exactly one requester (grant) to mem_* each cycle; mem_wr/size/addr/wstrb/wdata are combinational copies of the granted requester's fields.
REQ-017 SHALL drive mem_req = granted x_req AND NOT full, where full means count == OT_DEPTH.
REQ-018 SHALL drive x_addr_ok = mem_req AND mem_addr_ok AND grant==x; the non-granted requester's addr_ok is 0.
REQ-019 SHALL arbitrate with FSM states IDLE, LOCK_INST, LOCK_DATA.
REQ-020 In IDLE: single requester wins; on contention the requester not equal to register last wins; last resets to inst, so data wins the first contention.
REQ-021 IDLE -> LOCK_x when mem_req high for x and mem_addr_ok low; LOCK_x -> IDLE on mem_req AND mem_addr_ok; in LOCK_x grant is forced to x regardless of other requests.
REQ-022 SHALL update last to x on every accepted handshake (mem_req AND mem_addr_ok).
REQ-023 SHALL keep an in-order ID FIFO of depth OT_DEPTH (1-bit ID: 0=inst, 1=data) with count width log2(OT_DEPTH)+1.
REQ-024 SHALL push granted ID on accepted handshake and pop on mem_data_ok when count>0; simultaneous push and pop leaves count unchanged; pointers wrap modulo OT_DEPTH.
REQ-025 SHALL drive x_data_ok = mem_data_ok AND count>0 AND head ID==x, same cycle (zero latency); x_rdata = mem_rdata for both requesters.
REQ-026 mem_data_ok with count==0: SHALL generate no x_data_ok, leave FIFO unchanged, set protocol_err until reset.
REQ-027 When full, a pop in the same cycle SHALL NOT enable a push; mem_req asserts again the following cycle.
REQ-028 Responses SHALL be returned strictly in acceptance order.

Reset
REQ-029 resetn low SHALL immediately clear state=IDLE, last=inst, count=0, read/write pointers=0, protocol_err=0.
REQ-030 While resetn is low SHALL force mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok to 0; in-flight transactions are discarded, with no responses routed after release.

Verification
REQ-031 Both requests high, mem_addr_ok=1 every cycle -> grants alternate data, inst, data, inst; each addr_ok one cycle per grant.
REQ-032 inst_req alone, mem_addr_ok low 3 cycles, data_req rises in cycle 2 -> grant stays inst (LOCK_INST) until cycle-4 handshake, then data granted.
REQ-033 OT_DEPTH=4, four accepted reads, no data_ok -> mem_req low in cycle 5; one mem_data_ok -> mem_req high next cycle, not same cycle.
REQ-034 Accept order inst, data, data; three mem_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok(0x11), data_data_ok(0x22), data_data_ok(0x33).
REQ-035 mem_data_ok with count=0 -> no x_data_ok, protocol_err=1 held until resetn low.
REQ-036 resetn low with two outstanding, release, then mem_data_ok -> no x_data_ok, protocol_err=1.
